// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory bus arbiter: FSM states, owner encoding and
// default parameter values.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnLs = 1'b1
  } owner_e;

  localparam int unsigned DefWidth       = 64;
  localparam int unsigned DefInstWidth   = 32;
  localparam int unsigned DefStarveLimit = 4;
  localparam int unsigned DefTimeout     = 255;

endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// Grant logic for the arbiter: LSU wins by default; IF wins once the LSU has been granted
// STARVE_LIMIT times in a row while IF was waiting.
module mem_bus_arbiter_grant
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_idle,
  input  logic i_if_valid,
  input  logic i_ls_valid,
  output logic o_grant_if,
  output logic o_grant_ls
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CntW-1:0] LimitVal = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] r_starve_cnt;
  logic            w_if_turn;

  assign w_if_turn  = i_if_valid && (r_starve_cnt == LimitVal);
  assign o_grant_if = i_idle && i_if_valid && (!i_ls_valid || w_if_turn);
  assign o_grant_ls = i_idle && i_ls_valid && !w_if_turn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (o_grant_if) begin
      r_starve_cnt <= '0;
    end else if (o_grant_ls && i_if_valid && (r_starve_cnt != LimitVal)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: one outstanding transaction shared between IF and LSU.
// Define MEM_ARB_TIMEOUT_EN to enable the response watchdog (*_rsp_err).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned INST_WIDTH   = DefInstWidth,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit,
  parameter int unsigned TIMEOUT      = DefTimeout
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [WIDTH-1:0]      if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [INST_WIDTH-1:0] if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [WIDTH-1:0]      ls_req_addr,
  input  logic [WIDTH-1:0]      ls_req_wdata,
  input  logic [WIDTH/8-1:0]    ls_req_wstrb,
  output logic                  ls_req_ready,
  output logic                  ls_rsp_valid,
  output logic [WIDTH-1:0]      ls_rsp_rdata,
  output logic                  ls_rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [WIDTH-1:0]      mem_req_addr,
  output logic                  mem_req_we,
  output logic [WIDTH-1:0]      mem_req_wdata,
  output logic [WIDTH/8-1:0]    mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [WIDTH-1:0]      mem_rsp_rdata,
  output logic                  hold_pipeline_o
);

  arb_state_e           r_state, w_state_d;
  owner_e               r_owner;
  logic [WIDTH-1:0]     r_addr, r_wdata, r_rdata;
  logic                 r_we;
  logic [WIDTH/8-1:0]   r_wstrb;
  logic                 w_grant_if, w_grant_ls;
  logic                 w_timeout, w_err;

  mem_bus_arbiter_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_idle    (r_state == StIdle),
    .i_if_valid(if_req_valid),
    .i_ls_valid(ls_req_valid),
    .o_grant_if(w_grant_if),
    .o_grant_ls(w_grant_ls)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 2);
  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_err;

  assign w_timeout = (r_state == StWait) && !mem_rsp_valid && (r_tmo_cnt == TmoW'(TIMEOUT));
  assign w_err     = r_err;

  // Cleared throughout REQ so it holds 0 on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == StReq) begin
        r_tmo_cnt <= '0;
      end else if (r_state == StWait) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if ((r_state == StWait) && mem_rsp_valid) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT == 0);
  assign w_timeout    = 1'b0;
  assign w_err        = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_if || w_grant_ls) w_state_d = StReq;
      StReq:   if (mem_req_ready) w_state_d = StWait;
      StWait:  if (mem_rsp_valid || w_timeout) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_owner <= OwnIf;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_grant_ls) begin
        r_owner <= OwnLs;
        r_addr  <= ls_req_addr;
        r_we    <= ls_req_we;
        r_wdata <= ls_req_wdata;
        r_wstrb <= ls_req_wstrb;
      end else if (w_grant_if) begin
        r_owner <= OwnIf;
        r_addr  <= if_req_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_wstrb <= '0;
      end
      if ((r_state == StWait) && mem_rsp_valid) begin
        r_rdata <= mem_rsp_rdata;
      end else if (w_timeout) begin
        r_rdata <= '0;
      end
    end
  end

  // Every output is forced low while reset is asserted, including the combinational grants.
  always_comb begin
    if_req_ready    = 1'b0;
    if_rsp_valid    = 1'b0;
    if_rsp_data     = '0;
    if_rsp_err      = 1'b0;
    ls_req_ready    = 1'b0;
    ls_rsp_valid    = 1'b0;
    ls_rsp_rdata    = '0;
    ls_rsp_err      = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_req_we      = 1'b0;
    mem_req_wdata   = '0;
    mem_req_wstrb   = '0;
    hold_pipeline_o = 1'b0;
    if (rst_n) begin
      if_req_ready = w_grant_if;
      ls_req_ready = w_grant_ls;
      if (r_state == StReq) begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_addr;
        mem_req_we    = r_we;
        mem_req_wdata = r_wdata;
        mem_req_wstrb = r_wstrb;
      end
      if (r_state == StResp) begin
        if (r_owner == OwnIf) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = r_addr[2] ? r_rdata[2*INST_WIDTH-1:INST_WIDTH]
                                   : r_rdata[INST_WIDTH-1:0];
          if_rsp_err   = w_err;
        end else begin
          ls_rsp_valid = 1'b1;
          ls_rsp_rdata = r_we ? '0 : r_rdata;
          ls_rsp_err   = w_err;
        end
      end
      hold_pipeline_o = (ls_req_valid && !w_grant_ls) ||
                        ((r_owner == OwnLs) && (r_state != StIdle));
    end
  end

endmodule
